// File: rtl/gpio_pkg.sv
// Shared write-mode codes and serial engine state encoding for the GPIO output port.
// Pure constants/types: no latency, no flow control.
package gpio_pkg;

    localparam logic [1:0] WM_ALL = 2'b00;
    localparam logic [1:0] WM_SET = 2'b01;
    localparam logic [1:0] WM_CLR = 2'b10;
    localparam logic [1:0] WM_TGL = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } p2s_state_t;

endpackage

// File: rtl/led_p2s_engine.sv
// Serialises an LED snapshot onto led_clk/led_sout; frame = 2 + 2*CLK_DIV*LED_BITS cycles after req.
// No backpressure: requests arriving mid-frame collapse into a single pending frame.
module led_p2s_engine
    import gpio_pkg::*;
#(
    parameter int LED_BITS = 16,
    parameter int CLK_DIV  = 1,
    parameter int DIR      = 0
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                req,
    input  logic [LED_BITS-1:0] data,
    output logic                led_clk,
    output logic                led_sout,
    output logic                led_clrn,
    output logic                led_pen,
    output logic                busy,
    output logic                done
);

    localparam int CNT_W = (LED_BITS > 1) ? $clog2(LED_BITS) : 1;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HEAD  = (DIR != 0) ? 0 : LED_BITS - 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LED_BITS - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    p2s_state_t          state;
    logic                pending;
    logic [CNT_W-1:0]    bit_cnt;
    logic [DIV_W-1:0]    div_cnt;
    logic [LED_BITS-1:0] sr;
    logic [LED_BITS-1:0] sr_nxt;

    // The bit on led_sout is always the head of sr; advancing shifts the next bit into the head.
    always_comb begin
        sr_nxt = (DIR != 0) ? (sr >> 1) : (sr << 1);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= IDLE;
            pending  <= 1'b1;
            led_clk  <= 1'b0;
            led_sout <= 1'b0;
            led_clrn <= 1'b0;
            led_pen  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bit_cnt  <= '0;
            div_cnt  <= '0;
            sr       <= '0;
        end else begin
            led_clrn <= 1'b1;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    led_pen <= 1'b1;
                    busy    <= 1'b0;
                    led_clk <= 1'b0;
                    if (req || pending) begin
                        state   <= LOAD;
                        busy    <= 1'b1;
                        led_pen <= 1'b0;
                    end
                end
                LOAD: begin
                    sr       <= data;
                    led_sout <= data[HEAD];
                    bit_cnt  <= '0;
                    div_cnt  <= '0;
                    led_clk  <= 1'b0;
                    pending  <= req;
                    state    <= SHIFT;
                end
                SHIFT: begin
                    if (req) pending <= 1'b1;
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (!led_clk) begin
                            led_clk <= 1'b1;
                        end else begin
                            led_clk <= 1'b0;
                            if (bit_cnt == CNT_LAST) begin
                                state    <= DONE;
                                done     <= 1'b1;
                                busy     <= 1'b0;
                                led_pen  <= 1'b1;
                                led_sout <= 1'b0;
                            end else begin
                                bit_cnt  <= bit_cnt + 1'b1;
                                sr       <= sr_nxt;
                                led_sout <= sr_nxt[HEAD];
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (req) pending <= 1'b1;
                    if (pending) begin
                        state   <= LOAD;
                        busy    <= 1'b1;
                        led_pen <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/gpio_p2s_port.sv
// CPU GPIO output port: {aux, led, cnt} registers with set/clear/toggle on LED, plus serial LED refresh.
// Writes visible one cycle later; never stalls the CPU, frame requests queue one deep.
module gpio_p2s_port
    import gpio_pkg::*;
#(
    parameter int                LED_BITS     = 16,
    parameter int                CNT_BITS     = 2,
    parameter int                AUX_BITS     = 14,
    parameter logic [LED_BITS-1:0] RST_LED    = 16'h002A,
    parameter int                CLK_DIV      = 1,
    parameter int                DIR          = 0,
    parameter int                INVERT       = 1,
    parameter int                AUTO_REFRESH = 1,
    localparam int               DATA_W       = AUX_BITS + LED_BITS + CNT_BITS
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                EN,
    input  logic [1:0]          wr_mode,
    input  logic [DATA_W-1:0]   P_Data,
    input  logic                Start,
    output logic [CNT_BITS-1:0] counter_set,
    output logic [LED_BITS-1:0] LED_out,
    output logic [AUX_BITS-1:0] GPIOf0,
    output logic                led_clk,
    output logic                led_sout,
    output logic                led_clrn,
    output logic                LED_PEN,
    output logic                busy,
    output logic                done
);

    logic [LED_BITS-1:0] mask;
    logic [LED_BITS-1:0] snap;
    logic                req;

    assign mask = P_Data[CNT_BITS +: LED_BITS];
    assign req  = Start | (EN & (AUTO_REFRESH != 0));
    assign snap = (INVERT != 0) ? ~LED_out : LED_out;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            LED_out     <= RST_LED;
            counter_set <= '0;
            GPIOf0      <= '0;
        end else if (EN) begin
            case (wr_mode)
                WM_ALL: begin
                    counter_set <= P_Data[CNT_BITS-1:0];
                    LED_out     <= mask;
                    GPIOf0      <= P_Data[DATA_W-1 -: AUX_BITS];
                end
                WM_SET:  LED_out <= LED_out | mask;
                WM_CLR:  LED_out <= LED_out & ~mask;
                default: LED_out <= LED_out ^ mask;
            endcase
        end
    end

    led_p2s_engine #(
        .LED_BITS (LED_BITS),
        .CLK_DIV  (CLK_DIV),
        .DIR      (DIR)
    ) u_engine (
        .clk      (clk),
        .rstn     (rstn),
        .req      (req),
        .data     (snap),
        .led_clk  (led_clk),
        .led_sout (led_sout),
        .led_clrn (led_clrn),
        .led_pen  (LED_PEN),
        .busy     (busy),
        .done     (done)
    );

endmodule
